romulus_pdi_feeder: RTL

// - Producer side of the 32-bit state-update datapath: accepts message/ciphertext words from the bus,

---
 rtl/romulus_pdi_feeder_pkg.sv | 30 +++
 rtl/romulus_pdi_feeder_if.sv | 35 +++
 rtl/romulus_pad_lane.sv | 55 +++++
 rtl/romulus_pdi_feeder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/romulus_pdi_feeder_pkg.sv
// ---------------------------------------------------------------------------
// romulus_pdi_feeder_pkg
// Shared definitions for the Romulus PDI feeder:
//   - FSM state encoding
//   - block geometry (words per block, bytes per block)
//   - lane that carries the padding length byte
//   - clamp_size(): maps a 3-bit byte count onto 0..4
// ---------------------------------------------------------------------------
package romulus_pdi_feeder_pkg;

  localparam int         WORDS_PER_BLK = 4;
  localparam logic [4:0] BLK_BYTES     = 5'd16;
  // Lane 0 is pdi[7:0]; on word 3 it holds byte 15, the padding length byte.
  localparam int         PAD_LEN_LANE  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Sizes above 4 cannot describe a 32-bit word; treat them as a full word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'd4) ? 3'd4 : size;
  endfunction

endpackage

// File: rtl/romulus_pdi_feeder_if.sv
// ---------------------------------------------------------------------------
// romulus_pdi_feeder_if
// Input word bus feeding the PDI feeder.
//   bdi        32  input word, byte 0 in bdi[31:24]
//   bdi_valid   1  word present
//   bdi_size    3  valid bytes (0..4, MSB-aligned), meaningful with bdi_last
//   bdi_last    1  final word of the message
//   bdi_ready   1  word taken when bdi_valid & bdi_ready
// Modports: master = word source, slave = feeder.
// ---------------------------------------------------------------------------
interface romulus_pdi_feeder_if;

  logic [31:0] bdi;
  logic        bdi_valid;
  logic [2:0]  bdi_size;
  logic        bdi_last;
  logic        bdi_ready;

  modport master (
    output bdi,
    output bdi_valid,
    output bdi_size,
    output bdi_last,
    input  bdi_ready
  );

  modport slave (
    input  bdi,
    input  bdi_valid,
    input  bdi_size,
    input  bdi_last,
    output bdi_ready
  );

endinterface

// File: rtl/romulus_pad_lane.sv
// ---------------------------------------------------------------------------
// romulus_pad_lane
// Combinational per-word byte masking and Romulus padding.
//   bdi        in  32  raw input word
//   size       in   3  valid bytes of a last word
//   last       in   1  word is the final message word
//   pad        in   1  emitting a padding word (no data at all)
//   wcnt       in   2  word position in the block
//   bcnt_prev  in   5  data bytes already in the block
//   pdi        out 32  masked/padded word
//   data_mask  out  4  lanes carrying real data (bit3 = bits [31:24])
//   bcnt_total out  5  data bytes in the block including this word
// ---------------------------------------------------------------------------
module romulus_pad_lane
  import romulus_pdi_feeder_pkg::*;
(
  input  logic [31:0] bdi,
  input  logic [2:0]  size,
  input  logic        last,
  input  logic        pad,
  input  logic [1:0]  wcnt,
  input  logic [4:0]  bcnt_prev,
  output logic [31:0] pdi,
  output logic [3:0]  data_mask,
  output logic [4:0]  bcnt_total
);

  logic [2:0] nbytes;
  logic       len_byte;

  // Only the last word may be short; earlier words always count as 4 bytes.
  assign nbytes     = pad ? 3'd0 : (last ? clamp_size(size) : 3'd4);
  assign bcnt_total = bcnt_prev + {2'b00, nbytes};
  // A short block carries its data length in byte 15.
  assign len_byte   = (wcnt == 2'd3) && (bcnt_total < BLK_BYTES);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      // Byte gi of the word lives in lane 3-gi.
      localparam int LANE = 3 - gi;
      logic is_data;

      assign is_data         = (3'(gi) < nbytes);
      assign data_mask[LANE] = is_data;

      if (LANE == PAD_LEN_LANE) begin : g_len
        assign pdi[LANE*8 +: 8] = is_data  ? bdi[LANE*8 +: 8] :
                                  len_byte ? {3'b000, bcnt_total} : 8'h00;
      end else begin : g_plain
        assign pdi[LANE*8 +: 8] = is_data ? bdi[LANE*8 +: 8] : 8'h00;
      end
    end
  endgenerate

endmodule

// File: rtl/romulus_pdi_feeder.sv
// ---------------------------------------------------------------------------
// romulus_pdi_feeder
// Producer side of the 32-bit Romulus state-update path. Takes message or
// ciphertext words from the bus, builds 128-bit blocks of four words with
// Romulus padding, and sequences each block against the SKINNY core.
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   dec_mode     in   1 = decryption, sampled with msg_start
//   msg_start    in   1-cycle pulse in IDLE to begin a message
//   bdi_bus      slave modport of romulus_pdi_feeder_if
//   skinny_done  in   1-cycle pulse: block cipher finished
//   pdi          out  padded word toward the state update
//   decrypt      out  per-lane pdo select (bit3 = bits [31:24])
//   enc, se      out  state-register enable / shift-enable, high per word
//   blk_start    out  1-cycle pulse after the 4th word of a block
//   blk_full     out  with blk_start: block holds 16 data bytes
//   msg_done     out  1-cycle pulse after the last block completes
// ---------------------------------------------------------------------------
module romulus_pdi_feeder
  import romulus_pdi_feeder_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int FFTYPE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_mode,
  input  logic                       msg_start,
  romulus_pdi_feeder_if.slave        bdi_bus,
  input  logic                       skinny_done,
  output logic [31:0]                pdi,
  output logic [3:0]                 decrypt,
  output logic                       enc,
  output logic                       se,
  output logic                       blk_start,
  output logic                       blk_full,
  output logic                       msg_done
);

  // Index of the final word in a block; only NWORDS = 4 is meaningful.
  localparam logic [1:0] WCNT_LAST = 2'(NWORDS - 1);

  // The state-register flavour does not change the feeder's behaviour.
  generate
    if (FFTYPE != 0) begin : g_ff_style_reg
    end else begin : g_ff_style_cg
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [1:0] wcnt_reg,  wcnt_next;
  logic [4:0] bcnt_reg,  bcnt_next;
  logic       last_reg,  last_next;
  logic       dec_reg,   dec_next;

  logic        emit;
  logic [31:0] lane_pdi;
  logic [3:0]  lane_mask;
  logic [4:0]  bcnt_total;

  romulus_pad_lane u_pad_lane (
    .bdi        (bdi_bus.bdi),
    .size       (bdi_bus.bdi_size),
    .last       (bdi_bus.bdi_last),
    .pad        (state_reg == ST_PAD),
    .wcnt       (wcnt_reg),
    .bcnt_prev  (bcnt_reg),
    .pdi        (lane_pdi),
    .data_mask  (lane_mask),
    .bcnt_total (bcnt_total)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      wcnt_reg  <= 2'd0;
      bcnt_reg  <= 5'd0;
      last_reg  <= 1'b0;
      dec_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      bcnt_reg  <= bcnt_next;
      last_reg  <= last_next;
      dec_reg   <= dec_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    wcnt_next         = wcnt_reg;
    bcnt_next         = bcnt_reg;
    last_next         = last_reg;
    dec_next          = dec_reg;
    bdi_bus.bdi_ready = 1'b0;
    emit              = 1'b0;
    blk_start         = 1'b0;
    blk_full          = 1'b0;
    msg_done          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (msg_start) begin
          state_next = ST_LOAD;
          wcnt_next  = 2'd0;
          bcnt_next  = 5'd0;
          last_next  = 1'b0;
          dec_next   = dec_mode;
        end
      end

      ST_LOAD: begin
        bdi_bus.bdi_ready = 1'b1;
        if (bdi_bus.bdi_valid) begin
          emit      = 1'b1;
          wcnt_next = wcnt_reg + 2'd1;
          bcnt_next = bcnt_total;
          last_next = last_reg | bdi_bus.bdi_last;
          if (wcnt_reg == WCNT_LAST) begin
            state_next = ST_START;
          end else if (bdi_bus.bdi_last) begin
            state_next = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        emit      = 1'b1;
        wcnt_next = wcnt_reg + 2'd1;
        if (wcnt_reg == WCNT_LAST) begin
          state_next = ST_START;
        end
      end

      ST_START: begin
        blk_start  = 1'b1;
        blk_full   = (bcnt_reg == BLK_BYTES);
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        // The bus stays stalled here even on the skinny_done cycle.
        if (skinny_done) begin
          if (last_reg) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_LOAD;
            bcnt_next  = 5'd0;
          end
        end
      end

      ST_DONE: begin
        msg_done   = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are zero whenever no word is being emitted.
  assign pdi     = emit ? lane_pdi : 32'h0;
  assign decrypt = emit ? ({4{dec_reg}} & lane_mask) : 4'b0000;
  assign enc     = emit;
  assign se      = emit;

endmodule
